// File: rtl/mips_fetch_pkg.sv
// Shared definitions for the instruction-fetch stage: reset PC, instruction
// field positions, word stride and the buffer entry layout.
package mips_fetch_pkg;

  localparam logic [31:0] DEF_RESET_PC = 32'h0000_0000;
  localparam int          OPCODE_MSB   = 31;
  localparam int          OPCODE_LSB   = 26;
  localparam int          FUNCT_MSB    = 5;
  localparam int          FUNCT_LSB    = 0;
  localparam int          JIDX_W       = 26;
  localparam logic [31:0] WORD_STRIDE  = 32'd4;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
  } fetch_entry_t;

  // j target: upper nibble of the sequential PC, word index from the instruction.
  function automatic logic [31:0] jump_target(input logic [31:0] pc_plus4,
                                              input logic [31:0] instr_word);
    return {pc_plus4[31:28], instr_word[JIDX_W-1:0], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_buffer.sv
// In-order FIFO of {instr, pc} returned by instruction memory; flush empties
// it in one cycle and wins over a same-cycle push or pop.
module fetch_buffer
  import mips_fetch_pkg::*;
#(
  parameter int DEPTH = 2,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = AW + 1
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         i_push,
  input  fetch_entry_t i_push_data,
  input  logic         i_pop,
  input  logic         i_flush,
  output fetch_entry_t o_head,
  output logic [CW-1:0] o_count,
  output logic         o_full,
  output logic         o_empty
);

  fetch_entry_t  r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [CW-1:0] r_count;
  logic          w_do_push;
  logic          w_do_pop;

  assign w_do_push = i_push && !i_flush;
  assign w_do_pop  = i_pop && !o_empty && !i_flush;

  always_ff @(posedge clk) begin
    if (reset || i_flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      r_count <= r_count + CW'(w_do_push) - CW'(w_do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wr_ptr] <= i_push_data;
  end

  assign o_head  = r_mem[r_rd_ptr];
  assign o_count = r_count;
  assign o_full  = (r_count == CW'(DEPTH));
  assign o_empty = (r_count == '0);

  // A push into a full buffer is only legal when the head leaves the same cycle.
  assert property (@(posedge clk) disable iff (reset) !(w_do_push && o_full && !i_pop));

endmodule

// File: rtl/imem_fetch_unit.sv
// Fetch stage: owns the PC, issues credit-limited requests to instruction
// memory, buffers replies in order and applies branch/jump redirects on consume.
module imem_fetch_unit
  import mips_fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = DEF_RESET_PC,
  parameter int          BUF_DEPTH = 2
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic        instr_valid,
  output logic [31:0] instr,
  output logic [31:0] instr_pc,
  output logic [31:0] pc_plus4,
  input  logic        instr_ready,
  input  logic        branch,
  input  logic        zero,
  input  logic        jump,
  input  logic [31:0] signimm
);

  localparam int CW = $clog2(BUF_DEPTH) + 1;

  logic [31:0]   r_fetch_pc;
  logic [31:0]   r_resp_pc;
  logic [CW-1:0] r_outstanding;
  logic [CW-1:0] r_discard;

  logic [CW-1:0] w_count;
  logic [CW-1:0] w_out_next;
  logic [CW:0]   w_credit_used;
  logic          w_full;
  logic          w_empty;
  logic          w_accept;
  logic          w_pop;
  logic          w_take;
  logic          w_drop;
  logic          w_push;
  logic [31:0]   w_target;
  fetch_entry_t  w_head;
  fetch_entry_t  w_push_data;

  // Words in flight and words already buffered both consume a buffer slot.
  assign w_credit_used = {1'b0, r_outstanding} + {1'b0, w_count};
  assign imem_req      = !reset && !w_full && (w_credit_used < (CW+1)'(BUF_DEPTH));
  assign imem_addr     = r_fetch_pc;
  assign w_accept      = imem_req && imem_ready;

  assign instr_valid = !w_empty;
  assign instr       = instr_valid ? w_head.instr : '0;
  assign instr_pc    = instr_valid ? w_head.pc    : '0;
  assign pc_plus4    = instr_pc + WORD_STRIDE;

  assign w_pop    = instr_valid && instr_ready;
  assign w_take   = w_pop && (jump || (branch && zero));
  assign w_target = jump ? jump_target(pc_plus4, instr) : pc_plus4 + (signimm << 2);

  // A reply arriving in the redirect cycle belongs to the old path.
  assign w_drop      = imem_rvalid && (r_discard != '0);
  assign w_push      = imem_rvalid && !w_drop && !w_take;
  assign w_push_data = '{instr: imem_rdata, pc: r_resp_pc};
  assign w_out_next  = r_outstanding + CW'(w_accept) - CW'(imem_rvalid);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_fetch_pc    <= RESET_PC;
      r_resp_pc     <= RESET_PC;
      r_outstanding <= '0;
      r_discard     <= '0;
    end else begin
      r_outstanding <= w_out_next;
      if (w_take) begin
        r_fetch_pc <= w_target;
        r_resp_pc  <= w_target;
        r_discard  <= w_out_next;
      end else begin
        if (w_accept) r_fetch_pc <= r_fetch_pc + WORD_STRIDE;
        if (w_push)   r_resp_pc  <= r_resp_pc + WORD_STRIDE;
        if (w_drop)   r_discard  <= r_discard - CW'(1);
      end
    end
  end

  fetch_buffer #(.DEPTH(BUF_DEPTH)) u_buf (
    .clk        (clk),
    .reset      (reset),
    .i_push     (w_push),
    .i_push_data(w_push_data),
    .i_pop      (w_pop),
    .i_flush    (w_take),
    .o_head     (w_head),
    .o_count    (w_count),
    .o_full     (w_full),
    .o_empty    (w_empty)
  );

endmodule

// File: tb/tb_imem_fetch_unit.sv
// Bench for imem_fetch_unit: 1-cycle in-order memory model, a core model that
// pushes the expected next PC on every consume, and reset/stall/redirect cases.
module tb_imem_fetch_unit;

  localparam int          DEPTH = 4;
  localparam logic [31:0] RPC   = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        reset;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        instr_valid;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic [31:0] pc_plus4;
  logic        instr_ready;
  logic        branch;
  logic        zero;
  logic        jump;
  logic [31:0] signimm;

  imem_fetch_unit #(.RESET_PC(RPC), .BUF_DEPTH(DEPTH)) dut (
    .clk        (clk),
    .reset      (reset),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_ready (imem_ready),
    .imem_rvalid(imem_rvalid),
    .imem_rdata (imem_rdata),
    .instr_valid(instr_valid),
    .instr      (instr),
    .instr_pc   (instr_pc),
    .pc_plus4   (pc_plus4),
    .instr_ready(instr_ready),
    .branch     (branch),
    .zero       (zero),
    .jump       (jump),
    .signimm    (signimm)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    int          stamp;
  } req_t;

  req_t        pend[$];
  logic [31:0] sb[$];
  int          n_cmp = 0;
  int          n_err = 0;
  int          cyc = 0;
  int          seg = 0;
  int          inflight = 0;
  bit          rst_q = 1'b1;
  bit          core_go = 1'b0;
  bit          mem_go = 1'b0;
  bit          redir_chk = 1'b0;
  logic [31:0] redir_tgt = '0;
  logic [31:0] last_pc = '1;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h (cycle %0d)", tag, act, exp, cyc);
    end
  endtask

  function automatic logic [31:0] word(input logic [31:0] a);
    if (a == 32'h4000_0010) return {6'h02, 26'h000_0040};
    return {6'h23, a[27:2]};
  endfunction

  // Control the core presents for the instruction at pc (segment 2 only).
  task automatic ctl(input logic [31:0] pc, output logic j, output logic b,
                     output logic z, output logic [31:0] imm);
    j = 1'b0; b = 1'b0; z = 1'b0; imm = '0;
    if (seg == 2) begin
      case (pc)
        32'h0000_0008: begin b = 1'b1; z = 1'b1; imm = 32'd3; end
        32'h0000_001C: begin b = 1'b1; z = 1'b0; imm = 32'd5; end
        32'h0000_0024: begin b = 1'b1; z = 1'b1; imm = 32'h0FFF_FFFA; end
        32'h4000_0010: begin j = 1'b1; b = 1'b1; z = 1'b1; imm = 32'd7; end
        default: ;
      endcase
    end
  endtask

  task automatic tick();
    logic        j, b, z, take;
    logic [31:0] imm, exp_pc, pp4, w, nxt;
    @(negedge clk);
    reset = rst_q;
    j = 1'b0; b = 1'b0; z = 1'b0; imm = '0; take = 1'b0; nxt = '0;
    if (rst_q) begin
      pend.delete();
      sb.delete();
      sb.push_back(RPC);
      imem_rvalid = 1'b0;
      imem_rdata  = '0;
      imem_ready  = 1'b0;
      instr_ready = 1'b0;
      inflight    = 0;
      redir_chk   = 1'b0;
      last_pc     = '1;
    end else begin
      if (pend.size() > 0 && pend[0].stamp < cyc) begin
        imem_rvalid = 1'b1;
        imem_rdata  = word(pend[0].addr);
        void'(pend.pop_front());
      end else begin
        imem_rvalid = 1'b0;
        imem_rdata  = '0;
      end
      imem_ready  = mem_go;
      instr_ready = core_go;
      if (instr_valid && core_go) begin
        chk("sb_depth", 32'(sb.size()), 32'd1);
        exp_pc = (sb.size() > 0) ? sb.pop_front() : 32'hDEAD_BEEF;
        chk("instr_pc", instr_pc, exp_pc);
        chk("instr", instr, word(exp_pc));
        chk("pc_plus4", pc_plus4, exp_pc + 32'd4);
        ctl(exp_pc, j, b, z, imm);
        pp4 = exp_pc + 32'd4;
        w   = word(exp_pc);
        if (j)           nxt = {pp4[31:28], w[25:0], 2'b00};
        else if (b && z) nxt = pp4 + (imm << 2);
        else             nxt = pp4;
        take = j || (b && z);
        sb.push_back(nxt);
        last_pc = exp_pc;
        inflight--;
      end
    end
    jump = j; branch = b; zero = z; signimm = imm;
    #1;
    if (!rst_q && imem_req && imem_ready) begin
      if (redir_chk) begin
        chk("redir_addr", imem_addr, redir_tgt);
        redir_chk = 1'b0;
      end
      pend.push_back('{addr: imem_addr, stamp: cyc});
      inflight++;
    end
    if (take) begin
      redir_chk = 1'b1;
      redir_tgt = nxt;
    end
    cyc++;
  endtask

  task automatic check_reset(input string tag);
    @(posedge clk);
    #1;
    chk({tag, "_req"},   imem_req,    32'd0);
    chk({tag, "_valid"}, instr_valid, 32'd0);
    chk({tag, "_instr"}, instr,       32'd0);
    chk({tag, "_pc"},    instr_pc,    32'd0);
  endtask

  task automatic run_until(input logic [31:0] pc, input int budget);
    int k = 0;
    while (last_pc != pc && k < budget) begin
      tick();
      k++;
    end
    chk("reach_pc", last_pc, pc);
  endtask

  initial begin
    reset = 1'b1; imem_ready = 1'b0; imem_rvalid = 1'b0; imem_rdata = '0;
    instr_ready = 1'b0; branch = 1'b0; zero = 1'b0; jump = 1'b0; signimm = '0;

    // Segment 1: streaming latency/throughput, then a 5-cycle consumer stall.
    seg = 1; core_go = 1'b1; mem_go = 1'b1; rst_q = 1'b1;
    tick();
    check_reset("rst");
    tick();
    rst_q = 1'b0;
    tick();
    chk("c0_req", imem_req, 32'd1);
    chk("c0_addr", imem_addr, RPC);
    chk("c0_valid", instr_valid, 32'd0);
    tick();
    chk("c1_valid", instr_valid, 32'd0);
    tick();
    chk("c2_valid", instr_valid, 32'd1);
    for (int i = 3; i < 10; i++) begin
      tick();
      chk("stream_valid", instr_valid, 32'd1);
    end
    core_go = 1'b0;
    for (int i = 1; i <= 5; i++) begin
      tick();
      chk("stall_valid", instr_valid, 32'd1);
      if (i >= 4) chk("stall_req", imem_req, 32'd0);
    end
    chk("stall_fill", 32'(inflight), 32'(DEPTH));
    core_go = 1'b1;
    run_until(32'h0000_0040, 60);

    // Segment 2: taken branch, not-taken branch, far branch, jump over branch.
    seg = 2; rst_q = 1'b1;
    tick(); tick();
    rst_q = 1'b0;
    run_until(32'h4000_0108, 120);

    // Segment 3: memory not ready, then reset mid-stream.
    seg = 3; mem_go = 1'b0; rst_q = 1'b1;
    tick(); tick();
    rst_q = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("nrdy_req", imem_req, 32'd1);
      chk("nrdy_addr", imem_addr, RPC);
      chk("nrdy_valid", instr_valid, 32'd0);
    end
    mem_go = 1'b1;
    tick(); tick(); tick(); tick();
    rst_q = 1'b1;
    tick();
    check_reset("mid_rst");
    rst_q = 1'b0;
    tick();
    chk("post_rst_addr", imem_addr, RPC);
    chk("post_rst_req", imem_req, 32'd1);
    run_until(32'h0000_0010, 40);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

endmodule
